instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 5-stage pipeline: issues word addresses to instruction memory, buffers returned instructions in a small prefetch FIFO, and presents them with OP/func fields split out to the decode stage and control decoder. It is the producer side of the decoder interface. It also consumes the decoder's branch outcome (PCSrc plus target) to redirect fetch and discard wrong-path instructions.

---
 rtl/instr_fetch_unit_pkg.sv | 32 +++
 rtl/instr_fetch_unit_fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared pipeline definitions: instruction width, OP/func field positions,
// fetch FSM state encoding and the prefetch buffer entry layout.
package instr_fetch_unit_pkg;

  localparam int INSTR_W  = 32;

  // Field positions within an instruction word
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  // Fetch FSM: IDLE = nothing outstanding, WAIT = response pending and kept,
  // DROP = response pending but belongs to a squashed (wrong) path.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One prefetch buffer entry: instruction plus the address of the next word
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus4;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch buffer between instruction memory and decode. Show-ahead: the
// head entry is visible as soon as count is non-zero. Flush empties the
// buffer in one cycle; simultaneous push and pop is legal even when full.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy control; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

  // Occupancy must stay within bounds; the fetch issue logic guarantees it
  ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == CW'(DEPTH)))
    else $error("fetch_fifo: push into a full buffer without a pop");

  ap_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count == '0))
    else $error("fetch_fifo: pop from an empty buffer");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Keeps at most one instruction-memory request in
// flight, buffers returned words in a small show-ahead FIFO and presents
// them to decode with the OP and func fields split out. A taken branch from
// the decoder redirects fetch, flushes the buffer and squashes any response
// still in flight.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
)
(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [5:0]         if_op,
  output logic [5:0]         if_func,
  output logic [INSTR_W-1:0] if_pc_plus4
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] pend_pc4;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               pop;
  logic               push;
  logic               issue;

  // Decode consumes the head whenever it is valid and not stalled
  assign pop  = if_valid && !id_stall;

  // Only a response we still want enters the buffer; a redirect kills it
  assign push = (state == ST_WAIT) && imem_rvalid && !redirect;

  // Occupancy after this cycle's push/pop; a new request may only go out if
  // its eventual response is guaranteed a free slot.
  assign occ  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

  assign push_entry = '{instr: imem_rdata, pc_plus4: pend_pc4};

  // Next-state and request generation
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc;

    if (!rst && !redirect && (occ < (CW+1)'(FIFO_DEPTH))) begin
      // A slot is free: issue from IDLE, or back-to-back as the pending
      // response returns in WAIT
      issue = (state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid);
    end
    imem_req = issue;

    unique case (state)
      ST_IDLE: begin
        if (issue) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)   state_next = issue ? ST_WAIT : ST_IDLE;
        else if (redirect) state_next = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and fetch PC; a redirect always wins over sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect)   fetch_pc <= word_align(redirect_pc);
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Remember pc+4 of the outstanding request so it travels with its data
  always_ff @(posedge clk) begin
    if (issue) pend_pc4 <= fetch_pc + 32'd4;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .head  (head),
    .count (count)
  );

  // Outputs read zero whenever nothing is presented
  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? head.instr    : '0;
  assign if_pc_plus4 = if_valid ? head.pc_plus4 : '0;
  assign if_op       = if_instr[OP_MSB:OP_LSB];
  assign if_func     = if_instr[FUNC_MSB:FUNC_LSB];

  // A response with nothing outstanding is a memory protocol violation
  ap_rvalid_idle: assert property (@(posedge clk) disable iff (rst)
    !(state == ST_IDLE && imem_rvalid))
    else $error("instr_fetch_unit: imem_rvalid with no request outstanding");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus a randomized stretch.
// A memory responder with variable latency feeds the DUT; the reference is
// a program-order stream model (expected next delivered pc, expected next
// fetch address) updated only by accepted instructions and redirects.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_op;
  logic [5:0]  if_func;
  logic [31:0] if_pc_plus4;

  // Second instance with a reset PC near the top of the address space
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_rvalid;
  logic [31:0] w_imem_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_id_stall;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [5:0]  w_if_op;
  logic [5:0]  w_if_func;
  logic [31:0] w_if_pc_plus4;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_stall(id_stall), .if_valid(if_valid),
    .if_instr(if_instr), .if_op(if_op), .if_func(if_func), .if_pc_plus4(if_pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .id_stall(w_id_stall), .if_valid(w_if_valid),
    .if_instr(w_if_instr), .if_op(w_if_op), .if_func(w_if_func),
    .if_pc_plus4(w_if_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // Memory model and reference stream state
  bit          const_mode;
  int          lat_min, lat_max;
  bit          pend;
  logic [31:0] pend_addr;
  int          due;
  int          cyc;
  logic [31:0] exp_pc;
  logic [31:0] issue_pc;
  int          n_issued, n_deliv;

  // Values sampled at the falling edge of the current cycle
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_instr, s_pc4;
  logic [5:0]  s_op, s_func;
  logic        w_s_req, w_s_valid;
  logic [31:0] w_s_addr, w_s_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (const_mode) return 32'h0000_0020;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: sample and check at negedge, then after the edge
  // advance the memory model and drive the next cycle's responses.
  task automatic tick();
    logic [31:0] w;
    logic [31:0] tgt;
    @(negedge clk);
    s_req    = imem_req;    s_addr  = imem_addr;   s_rvalid = imem_rvalid;
    s_valid  = if_valid;    s_instr = if_instr;    s_pc4    = if_pc_plus4;
    s_op     = if_op;       s_func  = if_func;
    w_s_req  = w_imem_req;  w_s_addr = w_imem_addr;
    w_s_valid = w_if_valid; w_s_pc4  = w_if_pc_plus4;
    if (!rst) begin
      tgt = {redirect_pc[31:2], 2'b00};
      if (redirect) chk("no_req_on_redirect", 32'(s_req), 32'd0);
      if (s_req) begin
        chk("issue_addr", s_addr, issue_pc);
        chk("single_outstanding", 32'(pend && !s_rvalid), 32'd0);
        issue_pc = issue_pc + 32'd4;
        n_issued++;
      end
      if (s_valid && !id_stall) begin
        w = word(exp_pc);
        chk("deliv_instr", s_instr, w);
        chk("deliv_op", 32'(s_op), 32'(w[31:26]));
        chk("deliv_func", 32'(s_func), 32'(w[5:0]));
        chk("deliv_pc4", s_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (redirect) begin
        exp_pc   = tgt;
        issue_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) pend = 1'b0;
    else begin
      if (s_rvalid) pend = 1'b0;
      if (s_req) begin
        pend      = 1'b1;
        pend_addr = s_addr;
        due       = (cyc - 1) + int'($urandom_range(lat_max, lat_min));
      end
    end
    imem_rvalid   = pend && (cyc == due);
    imem_rdata    = imem_rvalid ? word(pend_addr) : $urandom();
    w_imem_rvalid = !rst && w_s_req;
    w_imem_rdata  = 32'h0000_0020;
  endtask

  task automatic model_reset();
    pend = 1'b0; exp_pc = 32'h0; issue_pc = 32'h0;
    n_issued = 0; n_deliv = 0;
  endtask

  initial begin
    logic [31:0] hold_instr, hold_pc4;
    bit          found;
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    w_imem_rvalid = 1'b0; w_imem_rdata = 32'h0;
    w_redirect = 1'b0; w_redirect_pc = 32'h0; w_id_stall = 1'b0;
    const_mode = 1'b1; lat_min = 1; lat_max = 1; cyc = 0; due = 0;
    pend_addr = 32'h0;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_instr", s_instr, 32'h0);
    chk("rst_pc4", s_pc4, 32'h0);
    chk("rst_wrap_addr", w_s_addr, 32'hFFFF_FFF8);

    // Reset release with single-cycle memory
    rst = 1'b0;
    model_reset();
    tick();
    chk("c0_req", 32'(s_req), 32'd1);
    chk("c0_addr", s_addr, 32'h0);
    chk("c0_valid", 32'(s_valid), 32'd0);
    chk("wrap_c0_addr", w_s_addr, 32'hFFFF_FFF8);
    tick();
    chk("c1_addr", s_addr, 32'h4);
    chk("c1_valid", 32'(s_valid), 32'd0);
    chk("wrap_c1_addr", w_s_addr, 32'hFFFF_FFFC);
    tick();
    chk("c2_addr", s_addr, 32'h8);
    chk("c2_valid", 32'(s_valid), 32'd1);
    chk("c2_op", 32'(s_op), 32'h0);
    chk("c2_func", 32'(s_func), 32'h20);
    chk("c2_pc4", s_pc4, 32'h4);
    chk("wrap_c2_addr", w_s_addr, 32'h0);
    chk("wrap_c2_pc4", w_s_pc4, 32'hFFFF_FFFC);

    // Decode stall for six cycles
    id_stall = 1'b1;
    tick();
    chk("wrap_c3_valid", 32'(w_s_valid), 32'd1);
    chk("wrap_c3_pc4", w_s_pc4, 32'h0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_head_pc4", s_pc4, 32'h8);
    hold_instr = s_instr;
    hold_pc4   = s_pc4;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("stall_instr_stable", s_instr, hold_instr);
      chk("stall_pc4_stable", s_pc4, hold_pc4);
    end
    chk("stall_req_low", 32'(s_req), 32'd0);
    chk("stall_buffered", 32'(n_issued - n_deliv), 32'd2);
    chk("stall_none_pending", 32'(pend), 32'd0);
    id_stall = 1'b0;
    repeat (8) tick();

    // Three-cycle memory, redirect while a response is pending
    lat_min = 3; lat_max = 3;
    repeat (4) tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && !imem_rvalid) begin found = 1'b1; break; end
      tick();
    end
    chk("c_found_wait", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    const_mode = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_req) begin found = 1'b1; break; end
      chk("c_no_wrong_path", 32'(s_valid), 32'd0);
    end
    chk("c_target_req", 32'(found), 32'd1);
    chk("c_target_addr", s_addr, 32'h0000_0100);
    repeat (10) tick();

    // Redirect in the same cycle as a kept response
    lat_min = 2; lat_max = 2;
    repeat (4) tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && imem_rvalid) begin found = 1'b1; break; end
      tick();
    end
    chk("d_found_rvalid", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    tick();
    chk("d_fifo_empty", 32'(s_valid), 32'd0);
    chk("d_req", 32'(s_req), 32'd1);
    chk("d_addr", s_addr, 32'h0000_0200);
    repeat (6) tick();

    // Randomized stalls, redirects and latencies
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 300; i++) begin
      id_stall    = ($urandom_range(9, 0) < 3);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = $urandom();
      tick();
    end
    redirect = 1'b0; id_stall = 1'b0;
    repeat (12) tick();

    // Asynchronous reset in the middle of WAIT with data buffered
    lat_min = 3; lat_max = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    id_stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pend && !imem_rvalid && s_valid) begin found = 1'b1; break; end
    end
    chk("f_found_wait_buffered", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("f_async_req", 32'(imem_req), 32'd0);
    chk("f_async_addr", imem_addr, 32'h0);
    chk("f_async_valid", 32'(if_valid), 32'd0);
    chk("f_async_instr", if_instr, 32'h0);
    chk("f_async_pc4", if_pc_plus4, 32'h0);
    chk("f_async_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; w_imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; imem_rvalid = 1'b0; id_stall = 1'b0;
    model_reset();
    tick();
    chk("f_no_push", 32'(s_valid), 32'd0);
    chk("f_req", 32'(s_req), 32'd1);
    chk("f_addr", s_addr, 32'h0);
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
